case_demux: RTL

- Stream demultiplexer: one input stream carrying a select field, routed to one of NUM_OUT output streams. It is the inverse of the case-statement 4:1 selector.
- Each output has a one-entry registered buffer with valid/ready handshake, so outputs drain independently.
- An out-of-range select is consumed and dropped, and is counted as an error. This is the default branch.
- Sits between a single producer and per-channel consumers in the datapath.

---
 rtl/case_demux_pkg.sv | 18 +
 rtl/demux_slot.sv | 55 +++++
 rtl/case_demux.sv | 84 ++++++++
 3 files changed

// File: rtl/case_demux_pkg.sv
// Shared widths, limits and slot-state encoding for the case_demux stream demultiplexer.
package case_demux_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_OUT   = 4;
  localparam int DEF_SEL_W     = 2;
  localparam int DEF_ERR_CNT_W = 8;

  // Saturation value of the error counter at its default width.
  localparam logic [DEF_ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Per-channel buffer state: a slot either holds a word or it does not.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : case_demux_pkg

// File: rtl/demux_slot.sv
// One-entry valid/ready output buffer for a single demux channel.
// A load while the consumer drains reloads the slot, giving one word per cycle.
module demux_slot
  import case_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              ready_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // State register: synchronous reset discards any held or in-flight word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    if (rst) begin
      state_q <= SLOT_EMPTY;
      // NOTE: the payload register is reset too, because out_data must read 0 after reset.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: load fills or reloads; a drain without a load empties.
  always_comb begin
    // NOTE: hold-by-default assignments keep this block free of inferred latches.
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !load) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    // Payload only changes on a load; a plain drain leaves the last word visible.
    if (load) data_d = load_data;
  end

  // Outputs: space is available when empty or when the held word leaves this cycle.
  always_comb begin
    out_valid = (state_q == SLOT_FULL);
    ready_o   = !out_valid || out_ready;
    out_data  = data_q;
  end

endmodule : demux_slot

// File: rtl/case_demux.sv
// Stream demultiplexer: routes each input word to the output slot named by in_sel.
// Selects beyond the channel count are accepted, dropped and counted as errors.
module case_demux
  import case_demux_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_OUT   = DEF_NUM_OUT,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [DATA_W-1:0]         in_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      err,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_LIMIT = '1;

  logic [NUM_OUT-1:0]   slot_load;
  logic [NUM_OUT-1:0]   slot_ready;
  logic                 sel_in_range;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Select decode and in_ready mux; an unmatched select falls to the error
  // branch, which keeps in_ready high so bad words never stall the producer.
  always_comb begin
    slot_load    = '0;
    in_ready     = 1'b1;
    sel_in_range = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_in_range = 1'b1;
        in_ready     = slot_ready[k];
        slot_load[k] = in_valid && slot_ready[k];
      end
    end
  end

  // One buffered output slot per channel.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[k]),
      .load_data (in_data),
      .ready_o   (slot_ready[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W])
    );
  end

  // Error pulse and saturating counter for accepted out-of-range selects.
  always_comb begin
    err_d     = in_valid && !sel_in_range;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != ERR_CNT_LIMIT)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  // Error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule : case_demux
